// File: rtl/demux_4_output_4bit_reg.sv
// Registered 1-to-4 demux with per-channel valid flags, round-robin auto pointer and sticky overwrite flag.
// Latency: one cycle from load edge to output. Backpressure: none; FULL/OVF only report occupancy and overwrites.
module demux_4_output_4bit_reg #(
    parameter int WIDTH = 4
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic [WIDTH-1:0] In_B,
    input  logic [1:0]       S,
    input  logic             LD,
    input  logic             AUTO,
    input  logic [3:0]       CLR,
    output logic [WIDTH-1:0] B0,
    output logic [WIDTH-1:0] B1,
    output logic [WIDTH-1:0] B2,
    output logic [WIDTH-1:0] B3,
    output logic [3:0]       V,
    output logic             FULL,
    output logic [1:0]       PTR,
    output logic             OVF
);

    logic [WIDTH-1:0] r_b0, r_b1, r_b2, r_b3;
    logic [3:0]       r_v;
    logic [1:0]       r_ptr;
    logic             r_ovf;

    logic [1:0]       w_sel;
    logic [3:0]       w_load_mask;
    logic             w_overwrite;

    assign w_sel       = AUTO ? r_ptr : S;
    assign w_load_mask = LD ? (4'b0001 << w_sel) : 4'b0000;
    // A same-cycle clear on the target channel means the old word was consumed, so it is not an overwrite.
    assign w_overwrite = |(w_load_mask & r_v & ~CLR);

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_b0  <= '0;
            r_b1  <= '0;
            r_b2  <= '0;
            r_b3  <= '0;
            r_v   <= 4'b0000;
            r_ptr <= 2'd0;
            r_ovf <= 1'b0;
        end else begin
            // Load wins over clear on the targeted channel.
            r_v <= (r_v & ~CLR) | w_load_mask;
            if (w_overwrite) begin
                r_ovf <= 1'b1;
            end
            if (LD) begin
                case (w_sel)
                    2'd0: r_b0 <= In_B;
                    2'd1: r_b1 <= In_B;
                    2'd2: r_b2 <= In_B;
                    default: r_b3 <= In_B;
                endcase
                if (AUTO) begin
                    r_ptr <= r_ptr + 2'd1;
                end
            end
        end
    end

    assign B0   = r_b0;
    assign B1   = r_b1;
    assign B2   = r_b2;
    assign B3   = r_b3;
    assign V    = r_v;
    assign FULL = &r_v;
    assign PTR  = r_ptr;
    assign OVF  = r_ovf;

endmodule

// File: tb/tb_demux_4_output_4bit_reg.sv
// Directed bench for demux_4_output_4bit_reg with hand-computed expectations.
module tb_demux_4_output_4bit_reg;

    logic       CLK = 1'b0;
    logic       RST = 1'b0;
    logic [3:0] In_B = '0;
    logic [1:0] S = '0;
    logic       LD = 1'b0;
    logic       AUTO = 1'b0;
    logic [3:0] CLR = '0;
    logic [3:0] B0, B1, B2, B3;
    logic [3:0] V;
    logic       FULL;
    logic [1:0] PTR;
    logic       OVF;

    int n_chk = 0;
    int n_fail = 0;

    always #5 CLK = ~CLK;

    demux_4_output_4bit_reg #(.WIDTH(4)) dut (
        .CLK (CLK),
        .RST (RST),
        .In_B(In_B),
        .S   (S),
        .LD  (LD),
        .AUTO(AUTO),
        .CLR (CLR),
        .B0  (B0),
        .B1  (B1),
        .B2  (B2),
        .B3  (B3),
        .V   (V),
        .FULL(FULL),
        .PTR (PTR),
        .OVF (OVF)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Apply one cycle of stimulus, then return idle inputs #1 after the edge.
    task automatic cyc(input logic ld, input logic auto_i, input logic [1:0] s,
                       input logic [3:0] d, input logic [3:0] clr, input logic rst);
        LD = ld; AUTO = auto_i; S = s; In_B = d; CLR = clr; RST = rst;
        @(posedge CLK);
        #1;
        LD = 1'b0; CLR = 4'b0000; RST = 1'b0; AUTO = 1'b0; S = 2'd0; In_B = 4'h0;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, ".B0"}, {28'd0, B0}, 32'h0);
        chk({tag, ".B1"}, {28'd0, B1}, 32'h0);
        chk({tag, ".B2"}, {28'd0, B2}, 32'h0);
        chk({tag, ".B3"}, {28'd0, B3}, 32'h0);
        chk({tag, ".V"},  {28'd0, V},  32'h0);
        chk({tag, ".PTR"}, {30'd0, PTR}, 32'h0);
        chk({tag, ".OVF"}, {31'd0, OVF}, 32'h0);
        chk({tag, ".FULL"}, {31'd0, FULL}, 32'h0);
    endtask

    initial begin
        // Reset
        cyc(1'b0, 1'b0, 2'd0, 4'h0, 4'h0, 1'b1);
        chk_all_zero("rst");

        // Manual load to channel 2
        cyc(1'b1, 1'b0, 2'd2, 4'hA, 4'h0, 1'b0);
        chk("man.B2", {28'd0, B2}, 32'hA);
        chk("man.V", {28'd0, V}, 32'b0100);
        chk("man.B0", {28'd0, B0}, 32'h0);
        chk("man.B1", {28'd0, B1}, 32'h0);
        chk("man.B3", {28'd0, B3}, 32'h0);
        chk("man.PTR", {30'd0, PTR}, 32'd0);
        chk("man.FULL", {31'd0, FULL}, 32'd0);

        // Auto fill and wrap
        cyc(1'b0, 1'b0, 2'd0, 4'h0, 4'h0, 1'b1);
        for (int i = 1; i <= 4; i++) begin
            cyc(1'b1, 1'b1, 2'd3, 4'(i), 4'h0, 1'b0);
            chk("auto.PTR", {30'd0, PTR}, 32'(i % 4));
        end
        chk("auto.B0", {28'd0, B0}, 32'h1);
        chk("auto.B1", {28'd0, B1}, 32'h2);
        chk("auto.B2", {28'd0, B2}, 32'h3);
        chk("auto.B3", {28'd0, B3}, 32'h4);
        chk("auto.V", {28'd0, V}, 32'hF);
        chk("auto.FULL", {31'd0, FULL}, 32'd1);
        chk("auto.OVF0", {31'd0, OVF}, 32'd0);
        cyc(1'b1, 1'b1, 2'd0, 4'h5, 4'h0, 1'b0);
        chk("wrap.B0", {28'd0, B0}, 32'h5);
        chk("wrap.OVF", {31'd0, OVF}, 32'd1);
        chk("wrap.PTR", {30'd0, PTR}, 32'd1);

        // Clear vs load collision (OVF already sticky from the wrap)
        cyc(1'b1, 1'b0, 2'd1, 4'h7, 4'b0011, 1'b0);
        chk("coll.B1", {28'd0, B1}, 32'h7);
        chk("coll.V", {28'd0, V}, 32'b1110);
        chk("coll.OVF", {31'd0, OVF}, 32'd1);
        chk("coll.PTR", {30'd0, PTR}, 32'd1);

        // S ignored in AUTO mode: goes to PTR=1
        cyc(1'b1, 1'b1, 2'd3, 4'h9, 4'h0, 1'b0);
        chk("sign.B1", {28'd0, B1}, 32'h9);
        chk("sign.B3", {28'd0, B3}, 32'h4);
        chk("sign.PTR", {30'd0, PTR}, 32'd2);
        cyc(1'b1, 1'b0, 2'd0, 4'h6, 4'h0, 1'b0);
        chk("pre.FULL", {31'd0, FULL}, 32'd1);
        chk("pre.PTR", {30'd0, PTR}, 32'd2);

        // Reset mid-operation with a load in flight
        cyc(1'b1, 1'b1, 2'd0, 4'hF, 4'h0, 1'b1);
        chk_all_zero("rstmid");
        cyc(1'b1, 1'b1, 2'd0, 4'h8, 4'h0, 1'b0);
        chk("resume.B0", {28'd0, B0}, 32'h8);
        chk("resume.V", {28'd0, V}, 32'b0001);
        chk("resume.PTR", {30'd0, PTR}, 32'd1);

        // Idle cycle: In_B, S, AUTO ignored when LD=0
        cyc(1'b0, 1'b1, 2'd2, 4'hE, 4'h0, 1'b0);
        chk("idle.B2", {28'd0, B2}, 32'h0);
        chk("idle.PTR", {30'd0, PTR}, 32'd1);
        chk("idle.V", {28'd0, V}, 32'b0001);

        // Clear retains data
        cyc(1'b1, 1'b0, 2'd3, 4'hC, 4'h0, 1'b0);
        cyc(1'b0, 1'b0, 2'd0, 4'h0, 4'b1000, 1'b0);
        chk("clr.V", {28'd0, V}, 32'b0001);
        chk("clr.B3", {28'd0, B3}, 32'hC);
        cyc(1'b1, 1'b0, 2'd3, 4'hD, 4'h0, 1'b0);
        chk("clr.reload.B3", {28'd0, B3}, 32'hD);
        chk("clr.reload.OVF", {31'd0, OVF}, 32'd0);

        // Fresh collision: clear on target suppresses overwrite error
        cyc(1'b1, 1'b0, 2'd1, 4'h2, 4'h0, 1'b0);
        cyc(1'b1, 1'b0, 2'd1, 4'h3, 4'b0010, 1'b0);
        chk("coll2.B1", {28'd0, B1}, 32'h3);
        chk("coll2.V", {28'd0, V}, 32'b1011);
        chk("coll2.OVF", {31'd0, OVF}, 32'd0);

        // Plain overwrite sets OVF, which then stays set
        cyc(1'b1, 1'b0, 2'd1, 4'h4, 4'h0, 1'b0);
        chk("ovw.OVF", {31'd0, OVF}, 32'd1);
        cyc(1'b0, 1'b0, 2'd0, 4'h0, 4'hF, 1'b0);
        chk("sticky.OVF", {31'd0, OVF}, 32'd1);
        chk("sticky.V", {28'd0, V}, 32'b0000);
        chk("sticky.B1", {28'd0, B1}, 32'h4);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/demux_4_output_4bit_reg.md
DEMUX_4_OUTPUT_4BIT_REG -- requirements
Module: demux_4_output_4bit_reg

Interface
REQ-001 SHALL provide parameter: WIDTH, 4, data width of the input word and of each output word.
REQ-002 SHALL provide port: CLK  input  1  single clock; all state changes occur on the rising edge.
REQ-003 SHALL provide port: RST  input  1  reset, synchronous, active-high.
REQ-004 SHALL provide port: In_B  input  WIDTH  data word to be distributed.
REQ-005 SHALL provide port: S  input  2  manual channel select (0..3 -> B0..B3), used when AUTO=0.
REQ-006 SHALL provide port: LD  input  1  load strobe; one word is written per cycle with LD=1.
REQ-007 SHALL provide port: AUTO  input  1  1 = channel taken from internal pointer PTR; 0 = channel taken from S.
REQ-008 SHALL provide port: CLR  input  4  per-channel valid clear; bit i clears V[i].
REQ-009 SHALL provide ports: B0, B1, B2, B3  output  WIDTH each  registered channel data.
REQ-010 SHALL provide port: V  output  4  per-channel valid flags, bit i for Bi.
REQ-011 SHALL provide port: FULL  output  1  high when all four V bits are high.
REQ-012 SHALL provide port: PTR  output  2  round-robin pointer, i.e. the next AUTO channel.
REQ-013 SHALL provide port: OVF  output  1  sticky overwrite-error flag.

Function
REQ-014 SHALL select the destination channel as sel = AUTO ? PTR : S, evaluated in the cycle LD is high.
REQ-015 SHALL, on a rising edge with LD=1, write In_B into B<sel> and set V[sel]=1; the new value is visible on the output one cycle after the edge (latency 1).
REQ-016 SHALL hold every Bi unchanged in cycles where it is not the destination of a load; no other channel is disturbed.
REQ-017 SHALL, on a rising edge with CLR[i]=1, clear V[i] to 0 while leaving Bi data unchanged.
REQ-018 SHALL give load priority when LD targets channel i and CLR[i]=1 in the same cycle: V[i]=1 and Bi=In_B.
REQ-019 SHALL apply CLR to non-targeted channels normally in a cycle that also carries a load.
REQ-020 SHALL set OVF=1 when LD targets channel i while V[i]=1 and CLR[i]=0; the write still completes (new data overwrites).
REQ-021 SHALL keep OVF at 1 once set, until RST is asserted.
REQ-022 SHALL increment PTR by 1 modulo 4 (wrapping 3->0) on every edge with LD=1 and AUTO=1.
REQ-023 SHALL hold PTR unchanged when LD=0 or AUTO=0.
REQ-024 SHALL drive FULL as the AND of the V register bits, with no extra cycle of delay relative to V.
REQ-025 SHALL ignore S whenever AUTO=1, and ignore In_B, S and AUTO whenever LD=0.

Reset
REQ-026 SHALL, on a rising edge with RST=1, set B0-B3=0, V=4'b0000, PTR=0, OVF=0 and FULL=0, overriding LD and CLR in that cycle.
REQ-027 SHALL discard any load that is in progress when RST is asserted; no write from the RST cycle survives.

Verification
REQ-028 SHALL check manual load: AUTO=0, S=2, In_B=4'hA, LD=1 for one cycle -> next cycle B2=4'hA, V=4'b0100, B0/B1/B3=0, PTR=0, FULL=0.
REQ-029 SHALL check auto fill and wrap: AUTO=1, four consecutive LD cycles with In_B=1,2,3,4 -> B0..B3=1,2,3,4, V=4'b1111, FULL=1, PTR=0; a fifth load (In_B=5) -> B0=5, OVF=1, PTR=1.
REQ-030 SHALL check clear vs. load collision: V[1]=1, then LD with S=1, In_B=4'h7 and CLR=4'b0011 in the same cycle -> B1=7, V[1]=1, V[0]=0, OVF=1.
REQ-031 SHALL check clear retains data: B3=4'hC with V[3]=1, CLR=4'b1000 -> V[3]=0, B3 stays 4'hC; then LD to channel 3 -> OVF stays 0.
REQ-032 SHALL check reset mid-operation: with FULL=1, OVF=1 and PTR=2, assert RST together with LD=1 -> next cycle all outputs 0; released loads resume from PTR=0.
